// File: rtl/k580vt57_dma.sv
// k580vt57_dma: four-channel DMA sequencer (8257-compatible subset).
// Arbitrates channel requests, takes the bus through hrq/hlda and runs
// a four-state S1..S4 transfer cycle. Channel 2 autoloads from channel 3.
module k580vt57_dma #(
  parameter int NCH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      iaddr,
  input  logic [7:0]      idata,
  output logic [7:0]      odata,
  input  logic            iwe_n,
  input  logic            ird_n,
  input  logic [NCH-1:0]  drq,
  output logic [NCH-1:0]  dack,
  output logic            hrq,
  input  logic            hlda,
  output logic [15:0]     oaddr,
  output logic            omemr_n,
  output logic            omemw_n,
  output logic            oiord_n,
  output logic            oiowr_n,
  output logic            tc
);

  typedef enum logic [2:0] {ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4} state_t;

  // Channel registers: count bits 15:14 are the transfer type.
  logic [NCH-1:0][15:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [7:0]           mode_q, mode_d;
  logic                 ff_q, ff_d;
  logic [NCH-1:0]       tcf_q, tcf_d;
  logic                 upd_q, upd_d;
  logic                 iwe_n_q, ird_n_q;
  state_t               state_q, state_d;
  logic [1:0]           chan_q, chan_d, last_q, last_d;
  logic [NCH-1:0]       dack_q, dack_d;
  logic                 hrq_q, hrq_d, tc_q, tc_d;
  logic [15:0]          oaddr_q, oaddr_d;
  logic [3:0]           strb_q, strb_d;  // {memr, memw, iord, iowr}, active low

  logic                 wr_stb, rd_stb, cur_tc;
  logic [1:0]           sel_ch, win, ctype;
  logic [15:0]          sel_word;
  logic [NCH-1:0]       req_now, req_next;

  // Highest-priority requester; rotating mode starts just after base.
  function automatic logic [1:0] pick(input logic [NCH-1:0] req, input logic rot,
                                      input logic [1:0] base);
    logic [1:0] c;
    logic [1:0] w;
    w = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      c = rot ? base + 2'(k) : 2'(k - 1);
      if (req[c]) w = c;
    end
    return w;
  endfunction

  // CPU strobes act on their rising edge; ignored while the bus is granted.
  assign wr_stb   = iwe_n & ~iwe_n_q & ~hlda;
  assign rd_stb   = ird_n & ~ird_n_q & ~hlda;
  assign sel_ch   = iaddr[2:1];
  assign sel_word = iaddr[0] ? cnt_q[sel_ch] : addr_q[sel_ch];
  assign cur_tc   = (cnt_q[chan_q][13:0] == 14'd0);

  // CPU read mux, byte chosen by the shared flip-flop.
  always_comb begin
    odata = 8'h00;
    if (!iaddr[3])            odata = ff_q ? sel_word[15:8] : sel_word[7:0];
    else if (iaddr == 4'd8)   odata = {3'b000, upd_q, tcf_q};
  end

  // Register file next state: CPU accesses, then the S4 address/count update.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    addr_d = addr_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    ff_d   = ff_q;
    tcf_d  = tcf_q;
    upd_d  = upd_q;
    if (wr_stb) begin
      if (!iaddr[3]) begin
        ff_d = ~ff_q;
        for (int i = 0; i < NCH; i++) begin
          // A channel 2 write always lands in the channel 3 shadow as well.
          if (2'(i) == sel_ch || (sel_ch == 2'd2 && i == 3)) begin
            if (iaddr[0]) begin
              if (ff_q) cnt_d[i][15:8]  = idata;
              else      cnt_d[i][7:0]   = idata;
            end else begin
              if (ff_q) addr_d[i][15:8] = idata;
              else      addr_d[i][7:0]  = idata;
            end
          end
        end
      end else if (iaddr == 4'd8) begin
        mode_d = idata;
        ff_d   = 1'b0;
      end
    end
    if (rd_stb) begin
      if (!iaddr[3])          ff_d  = ~ff_q;
      else if (iaddr == 4'd8) tcf_d = '0;
    end
    if (state_q == ST_S4) begin
      addr_d[chan_q] = addr_q[chan_q] + 16'd1;
      cnt_d[chan_q]  = {cnt_q[chan_q][15:14], cnt_q[chan_q][13:0] - 14'd1};
      if (cur_tc) begin
        tcf_d[chan_q] = 1'b1;
        if (chan_q == 2'd2 && mode_q[7]) begin
          addr_d[2] = addr_q[3];
          cnt_d[2]  = cnt_q[3];
          upd_d     = 1'b1;
        end else if (mode_q[6]) begin
          mode_d[chan_q] = 1'b0;
        end
      end else if (chan_q == 2'd2) begin
        upd_d = 1'b0;
      end
    end
  end

  // Sequencer next state plus the outputs belonging to the state being entered.
  always_comb begin
    req_now  = drq & mode_q[NCH-1:0];
    req_next = drq & mode_d[NCH-1:0];
    win      = (state_q == ST_S4) ? pick(req_next, mode_q[4], chan_q)
                                  : pick(req_now, mode_q[4], last_q);
    state_d  = state_q;
    chan_d   = chan_q;
    last_d   = last_q;
    unique case (state_q)
      ST_IDLE: if (|req_now) state_d = ST_S0;
      ST_S0: begin
        if (!(|req_now)) state_d = ST_IDLE;
        else if (hlda) begin
          state_d = ST_S1;
          chan_d  = win;
        end
      end
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = ST_S3;
      ST_S3: state_d = ST_S4;
      ST_S4: begin
        last_d = chan_q;
        if ((|req_next) && hlda) begin
          state_d = ST_S1;
          chan_d  = win;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ctype   = cnt_q[chan_d][15:14];
    hrq_d   = (state_d != ST_IDLE);
    dack_d  = '0;
    strb_d  = 4'hF;
    tc_d    = 1'b0;
    oaddr_d = oaddr_q;
    unique case (state_d)
      ST_S1: begin
        dack_d[chan_d] = 1'b1;
        oaddr_d        = addr_d[chan_d];
      end
      ST_S2, ST_S3: begin
        dack_d[chan_d] = 1'b1;
        if (ctype == 2'b10) begin
          strb_d[3] = 1'b0;
          strb_d[0] = !(state_d == ST_S3 || mode_q[5]);
        end else if (ctype == 2'b01) begin
          strb_d[1] = 1'b0;
          strb_d[2] = !(state_d == ST_S3 || mode_q[5]);
        end
        tc_d = (state_d == ST_S3) && (cnt_q[chan_d][13:0] == 14'd0);
      end
      ST_S4: tc_d = (cnt_q[chan_d][13:0] == 14'd0);
      default: ;
    endcase
  end

  // State registers; the small register file is cleared on reset too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is a handful of flops, not a RAM, so it is reset like any other state.
      addr_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      ff_q    <= 1'b0;
      tcf_q   <= '0;
      upd_q   <= 1'b0;
      iwe_n_q <= 1'b1;
      ird_n_q <= 1'b1;
      state_q <= ST_IDLE;
      chan_q  <= 2'd0;
      last_q  <= 2'd3;
      dack_q  <= '0;
      hrq_q   <= 1'b0;
      tc_q    <= 1'b0;
      oaddr_q <= '0;
      strb_q  <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ff_q    <= ff_d;
      tcf_q   <= tcf_d;
      upd_q   <= upd_d;
      iwe_n_q <= iwe_n;
      ird_n_q <= ird_n;
      state_q <= state_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
      dack_q  <= dack_d;
      hrq_q   <= hrq_d;
      tc_q    <= tc_d;
      oaddr_q <= oaddr_d;
      strb_q  <= strb_d;
    end
  end

  assign dack    = dack_q;
  assign hrq     = hrq_q;
  assign tc      = tc_q;
  assign oaddr   = oaddr_q;
  assign omemr_n = strb_q[3];
  assign omemw_n = strb_q[2];
  assign oiord_n = strb_q[1];
  assign oiowr_n = strb_q[0];

endmodule
